// File: rtl/aes_mixcol_iter.sv
// aes_mixcol_iter -- iterative AES MixColumns / InvMixColumns engine.
//
// Accepts one 128-bit AES state per input handshake and transforms it
// COLS_PER_CYCLE columns at a time. A block takes NCYC = 4/COLS_PER_CYCLE
// BUSY cycles. The direction (forward or inverse) is chosen per block, so
// encrypt and decrypt rounds can share one unit.
//
// Build option:
//   MIXCOL_BYPASS_EN  when defined, adds the in_bypass port. A block latched
//                     with in_bypass=1 is passed through unchanged, with the
//                     same latency and handshake as a transformed block.
//
// Parameters:
//   COLS_PER_CYCLE    columns transformed per BUSY cycle: 1, 2 or 4.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input block offered
//   in_ready   unit can accept a block
//   in_data    state; column c = bits [127-32c -: 32], byte 0 in the MSBs
//   in_inv     0 = MixColumns, 1 = InvMixColumns (sampled with in_data)
//   in_bypass  (MIXCOL_BYPASS_EN only) pass the block through unchanged
//   out_valid  result held on out_data
//   out_ready  downstream accepts the result
//   out_data   transformed state, same byte layout as in_data
//   busy       high while the block is being transformed
module aes_mixcol_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
`ifdef MIXCOL_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCYC = 4 / COLS_PER_CYCLE;

    // Counter value of the final group of columns.
    localparam logic [1:0] LAST_COL = 2'((NCYC - 1) * COLS_PER_CYCLE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("aes_mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // GF(2^8) helpers, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of MixColumns (inv=0) or InvMixColumns (inv=1).
    // The inverse coefficients are assembled from the 2x/4x/8x multiples:
    //   9 = 8^1, B = 8^2^1, D = 8^4^1, E = 8^4^2.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [0:3][7:0] a;
        logic [0:3][7:0] x2;
        logic [0:3][7:0] x4;
        logic [0:3][7:0] x8;
        logic [0:3][7:0] r;
        a = col;
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (!inv) begin
                r[i] = x2[i]
                     ^ (x2[2'(i + 1)] ^ a[2'(i + 1)])
                     ^ a[2'(i + 2)]
                     ^ a[2'(i + 3)];
            end else begin
                r[i] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[2'(i + 1)] ^ x2[2'(i + 1)] ^ a[2'(i + 1)])
                     ^ (x8[2'(i + 2)] ^ x4[2'(i + 2)] ^ a[2'(i + 2)])
                     ^ (x8[2'(i + 3)] ^ a[2'(i + 3)]);
            end
        end
        return r;
    endfunction

    logic [1:0]       state_reg;
    logic [1:0]       cnt_reg;
    logic [0:3][31:0] data_reg;   // element c is column c (bits 127-32c -: 32)
    logic [0:3][31:0] res_reg;
    logic             inv_reg;
`ifdef MIXCOL_BYPASS_EN
    logic             byp_reg;
`endif

    logic [1:0]  lane_col [COLS_PER_CYCLE];
    logic [31:0] lane_out [COLS_PER_CYCLE];

    // One combinational transform core per lane; lane gi handles column
    // cnt_reg+gi of the latched state.
    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign lane_col[gi] = cnt_reg + 2'(gi);
`ifdef MIXCOL_BYPASS_EN
            assign lane_out[gi] = byp_reg ? data_reg[lane_col[gi]]
                                          : mix_col(data_reg[lane_col[gi]], inv_reg);
`else
            assign lane_out[gi] = mix_col(data_reg[lane_col[gi]], inv_reg);
`endif
        end
    endgenerate

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready = 1'b1;
            // Output and input handshakes may complete in the same cycle.
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_BUSY);
    assign out_data  = res_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            data_reg  <= '0;
            res_reg   <= '0;
            inv_reg   <= 1'b0;
`ifdef MIXCOL_BYPASS_EN
            byp_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        res_reg[lane_col[i]] <= lane_out[i];
                    end
                    // Wraps harmlessly when COLS_PER_CYCLE is 4.
                    cnt_reg <= cnt_reg + 2'(COLS_PER_CYCLE);
                    if (cnt_reg == LAST_COL) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready && !in_valid) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            // Accept path shared by IDLE and the back-to-back DONE case.
            // The result register is cleared so that columns not yet
            // written read as zero.
            if (in_valid && in_ready) begin
                data_reg  <= in_data;
                inv_reg   <= in_inv;
`ifdef MIXCOL_BYPASS_EN
                byp_reg   <= in_bypass;
`endif
                cnt_reg   <= 2'd0;
                res_reg   <= '0;
                state_reg <= ST_BUSY;
            end
        end
    end

endmodule

// File: tb/tb_aes_mixcol_iter.sv
`timescale 1ns/1ps
module tb_aes_mixcol_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } blk_t;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] COL_IN  = {32'hd4d4d4d5, 96'h0};
    localparam logic [127:0] COL_OUT = {32'hd5d5d7d6, 96'h0};

    task automatic chk(input int inst, input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL i%0d %s: got %h expected %h", inst, nm, act, exp);
        end
    endtask

    task automatic timeout(input int inst, input string nm);
        vectors++;
        miscompares++;
        $display("FAIL i%0d %s: wait bound expired, required the event to occur", inst, nm);
    endtask

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Matrix multiply of each column by the circulant coefficient row.
    function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input logic byp);
        logic [7:0] co [4];
        logic [7:0] a  [4];
        logic [7:0] r;
        logic [127:0] res;
        if (byp) return d;
        if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = d[127 - 32*c - 8*k -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(co[j], a[(i + j) % 4]);
                res[127 - 32*c - 8*i -: 8] = r;
            end
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int NC  = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        localparam int NCY = 4 / NC;

        logic         rst       = 1'b1;
        logic         in_valid  = 1'b0;
        logic         in_inv    = 1'b0;
        logic         out_ready = 1'b0;
        logic         byp       = 1'b0;
        logic [127:0] in_data   = '0;
        logic         in_ready;
        logic         out_valid;
        logic         busy;
        logic [127:0] out_data;
        logic         fin = 1'b0;
        int           acc_cyc = 0;
        blk_t         q[$];

        aes_mixcol_iter #(.COLS_PER_CYCLE(NC)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_inv    (in_inv),
`ifdef MIXCOL_BYPASS_EN
            .in_bypass (byp),
`endif
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .busy      (busy)
        );

        // Cycle-level reference: a block accepted at the handshake edge is
        // in flight for NCY cycles, then held until the output handshake.
        always @(negedge clk) begin : mon
            bit exp_ov;
            bit exp_ir;
            bit exp_busy;
            if (rst) begin
                q.delete();
                chk(gi, "rst_out_valid", out_valid, 0);
                chk(gi, "rst_out_data", out_data, 0);
                chk(gi, "rst_busy", busy, 0);
            end else begin
                exp_ov = 1'b0;
                if (q.size() > 0) exp_ov = (cyc >= q[0].acc + 1 + NCY);
                exp_ir   = (q.size() == 0) || (exp_ov && out_ready);
                exp_busy = (q.size() > 0) && !exp_ov;
                chk(gi, "out_valid", out_valid, exp_ov);
                chk(gi, "in_ready", in_ready, exp_ir);
                chk(gi, "busy", busy, exp_busy);
                if (exp_ov) chk(gi, "out_data", out_data, q[0].exp);
                if (exp_ov && out_ready) void'(q.pop_front());
                if (in_valid && exp_ir) q.push_back('{model(in_data, in_inv, byp), cyc});
            end
        end

        task automatic send(input logic [127:0] d, input logic inv, input logic b);
            int n;
            n = 0;
            in_data  = d;
            in_inv   = inv;
            byp      = b;
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) timeout(gi, "send");
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            // Scramble the inputs: they must be ignored while BUSY.
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = ~inv;
            byp      = ~b;
        endtask

        task automatic get(output logic [127:0] d, output int lat);
            int n;
            n = 0;
            out_ready = 1'b1;
            @(negedge clk);
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) timeout(gi, "get");
            d   = out_data;
            lat = cyc - acc_cyc - 1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        endtask

        initial begin : drv
            logic [127:0] d;
            logic [127:0] blk_b;
            logic [127:0] hold;
            int lat;
            int prev;
            int n;

            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;

            // Known-answer vectors in both directions.
            send(FWD_IN, 1'b0, 1'b0);
            get(d, lat);
            chk(gi, "fwd_vec", d, FWD_OUT);
            chk(gi, "fwd_latency", lat, NCY);
            send(INV_IN, 1'b1, 1'b0);
            get(d, lat);
            chk(gi, "inv_vec", d, INV_OUT);
            chk(gi, "inv_latency", lat, NCY);

            // Backpressure: hold out_ready low for 10 cycles in DONE while a
            // second block is offered.
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) timeout(gi, "bp_wait");
            hold = out_data;
            @(posedge clk);
            #1;
            blk_b    = {$urandom, $urandom, $urandom, $urandom};
            in_data  = blk_b;
            in_inv   = 1'b1;
            byp      = 1'b0;
            in_valid = 1'b1;
            repeat (10) begin
                @(negedge clk);
                chk(gi, "bp_in_ready", in_ready, 0);
                chk(gi, "bp_out_valid", out_valid, 1);
                chk(gi, "bp_out_data_stable", out_data, hold);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
            chk(gi, "bp_release_in_ready", in_ready, 1);
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            get(d, lat);
            chk(gi, "bp_second_block", d, model(blk_b, 1'b1, 1'b0));
            chk(gi, "bp_second_latency", lat, NCY);

            // Back-to-back with alternating direction.
            out_ready = 1'b1;
            in_valid  = 1'b1;
            prev = 0;
            for (int k = 0; k < 3; k++) begin
                in_data = {$urandom, $urandom, $urandom, $urandom};
                in_inv  = k[0];
                n = 0;
                @(negedge clk);
                while (!in_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) timeout(gi, "b2b_accept");
                if (k > 0) chk(gi, "b2b_accept_gap", cyc - prev, NCY + 1);
                prev = cyc;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            repeat (NCY + 3) @(posedge clk);
            #1;
            out_ready = 1'b0;

            // Randomized traffic against the reference.
            repeat (400) begin
                in_valid  = ($urandom_range(0, 2) != 0);
                in_data   = {$urandom, $urandom, $urandom, $urandom};
                in_inv    = 1'($urandom_range(0, 1));
`ifdef MIXCOL_BYPASS_EN
                byp       = 1'($urandom_range(0, 1));
`else
                byp       = 1'b0;
`endif
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            byp       = 1'b0;
            out_ready = 1'b1;
            repeat (NCY + 4) @(posedge clk);
            #1;
            out_ready = 1'b0;

            // Reset part-way through a block.
            send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk(gi, "async_rst_out_data", out_data, 0);
            chk(gi, "async_rst_out_valid", out_valid, 0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk(gi, "post_rst_in_ready", in_ready, 1);
            chk(gi, "post_rst_out_data", out_data, 0);
            @(posedge clk);
            #1;
            send(COL_IN, 1'b0, 1'b0);
            get(d, lat);
            chk(gi, "post_rst_vec", d, COL_OUT);
            chk(gi, "post_rst_latency", lat, NCY);

`ifdef MIXCOL_BYPASS_EN
            send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1);
            get(d, lat);
            chk(gi, "bypass_vec", d, 128'h00112233_44556677_8899aabb_ccddeeff);
            chk(gi, "bypass_latency", lat, NCY);
            send(FWD_IN, 1'b0, 1'b0);
            get(d, lat);
            chk(gi, "nobypass_vec", d, FWD_OUT);
`endif

            fin = 1'b1;
        end
    end

    initial begin : top
        logic all_fin;
        // Pin the reference model to the published vectors.
        chk(9, "model_fwd", model(FWD_IN, 1'b0, 1'b0), FWD_OUT);
        chk(9, "model_inv", model(INV_IN, 1'b1, 1'b0), INV_OUT);
        chk(9, "model_col", model(COL_IN, 1'b0, 1'b0), COL_OUT);
        all_fin = 1'b0;
        for (int i = 0; i < 30000 && !all_fin; i++) begin
            @(posedge clk);
            all_fin = g_inst[0].fin && g_inst[1].fin && g_inst[2].fin;
        end
        if (!all_fin) timeout(9, "watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_mixcol_iter.md
Name: aes_mixcol_iter

Overview:
Iterative, parametrised AES MixColumns / InvMixColumns engine with valid/ready handshakes on input and output. It processes one 128-bit state over 4/COLS_PER_CYCLE cycles, with the direction selectable per block. It sits in the AES round datapath between ShiftRows and AddRoundKey, so encrypt and decrypt rounds share one unit. Area and throughput are traded via COLS_PER_CYCLE.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
NCYC, 4/COLS_PER_CYCLE, derived localparam; BUSY cycles per block.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input block offered
in_ready  out  1  unit can accept a block
in_data  in  128  state; column c = bits [127-32c -: 32], byte 0 of each column in the MSBs
in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data
out_valid  out  1  result held on out_data
out_ready  in  1  downstream accepts the result
out_data  out  128  transformed state, same byte layout as in_data
busy  out  1  high while in the BUSY state

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; column counter=0; out_data=0; out_valid=0; busy=0; in_ready=1 once reset deasserts.
- Reset asserted mid-operation aborts the block immediately. The partial result is discarded and never presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid&in_ready: latch in_data and in_inv, clear the counter, go to BUSY.
- BUSY: in_ready=0; busy=1. Each cycle, columns counter..counter+COLS_PER_CYCLE-1 are transformed from the latched state into the result register, then counter += COLS_PER_CYCLE. After the last group: go to DONE and set out_valid=1. Any columns the result register has not yet been written for stay 0.
- DONE: out_valid=1; out_data stable until the output handshake.
  - out_ready=1: out_valid drops next cycle and the FSM returns to IDLE.
  - in_ready = out_ready, so a new block may be accepted in the same cycle as the output handshake and goes directly to BUSY (back-to-back).
  - in_valid while out_ready=0 is not accepted.
- Latency: out_valid rises exactly NCYC cycles after the input-handshake edge.
- Throughput: one block per NCYC+1 cycles with back-to-back handshakes.
- in_data and in_inv are ignored outside the input handshake; changing them during BUSY has no effect.
- Arithmetic: GF(2^8), polynomial 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0). All byte math is 8-bit XOR; no carries.
- Forward, bytes a0..a3 of a column, indices mod 4: r_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3).
- Inverse: r_i = 0E*a_i ^ 0B*a_(i+1) ^ 0D*a_(i+2) ^ 09*a_(i+3). Build this from xtime chains; no lookup tables.
- The transform core is purely combinational per column. The only registers are the latched input, the result, the counter, mode and FSM state.

Optional Feature:
MIXCOL_BYPASS_EN
- Defined: adds input port in_bypass (1 bit), sampled and latched with in_data. When latched as 1, out_data equals the latched in_data unchanged, using the same NCYC latency and the same handshake. This serves the AES final round, which skips MixColumns, so the round pipeline timing stays uniform.
- Undefined: no in_bypass port; every block is transformed.

Test Plan:
- Forward, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6, in_inv=0 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid rises 4 cycles after the accept edge.
- Inverse, COLS_PER_CYCLE=4: in_data=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, in_inv=1 -> out_data=db135345_f20a225c_d4d4d4d5_2d26314c one cycle after accept.
- Back-to-back, COLS_PER_CYCLE=2, out_ready held 1, in_valid held 1: three blocks accepted 3 cycles apart. Results appear in order, each 2 cycles after its accept, with alternating in_inv honoured per block.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_data and out_valid stable, in_ready=0, the offered next block is not accepted. Raising out_ready completes both handshakes in the same cycle.
- Reset mid-BUSY: assert rst after 2 of 4 cycles -> out_valid=0, out_data=0, in_ready=1 after release. A following block d4d4d4d5 in column 0 yields d5d5d7d6 with no stale data.
- MIXCOL_BYPASS_EN defined, in_bypass=1, in_data=00112233_44556677_8899aabb_ccddeeff -> identical out_data after NCYC cycles. With in_bypass=0 the result matches the forward vector.
